// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, waits for a stable lock, then releases the system reset.
// Optional retry limit with FAULT state is compiled in with `define PLL_LOCK_RETRY_LIMIT_EN.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 8,
    parameter int MAX_RETRIES   = 4
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             relock_req,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_count,
    output logic             fault
);

    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_LIM = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW      = (MAX_LIM > 1) ? $clog2(MAX_LIM) : 1;

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABLE,
        RUN
`ifdef PLL_LOCK_RETRY_LIMIT_EN
        ,
        FAULT
`endif
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [CNT_W-1:0] loss_reg, loss_next;
    logic [1:0]       sync_reg;
    logic             locked_s;
    logic             pll_rst_reg, pll_rst_next;
    logic             sys_rst_reg, sys_rst_next;
    logic             ready_reg, ready_next;

    // pll_locked is asynchronous to refclk
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], pll_locked};
        end
    end

    assign locked_s = sync_reg[1];

`ifdef PLL_LOCK_RETRY_LIMIT_EN
    localparam int RW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);

    logic [RW-1:0] retry_reg, retry_next;
    logic          fault_reg, fault_next;

    always_ff @(posedge refclk) begin
        if (rst) begin
            retry_reg <= '0;
            fault_reg <= 1'b0;
        end else begin
            retry_reg <= retry_next;
            fault_reg <= fault_next;
        end
    end

    assign fault = fault_reg;
`else
    // MAX_RETRIES only matters when the retry limit is compiled in.
    assign fault = (MAX_RETRIES > 0) ? 1'b0 : 1'b0;
`endif

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg   <= PLL_RESET;
            cnt_reg     <= '0;
            loss_reg    <= '0;
            pll_rst_reg <= 1'b1;
            sys_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            loss_reg    <= loss_next;
            pll_rst_reg <= pll_rst_next;
            sys_rst_reg <= sys_rst_next;
            ready_reg   <= ready_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        loss_next  = loss_reg;
`ifdef PLL_LOCK_RETRY_LIMIT_EN
        retry_next = retry_reg;
`endif
        case (state_reg)
            PLL_RESET: begin
                if (cnt_reg == RST_LAST) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (relock_req) begin
                    state_next = PLL_RESET;
                    cnt_next   = '0;
                end else if (locked_s) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    cnt_next = '0;
`ifdef PLL_LOCK_RETRY_LIMIT_EN
                    if (retry_reg == RETRY_LAST) begin
                        state_next = FAULT;
                    end else begin
                        state_next = PLL_RESET;
                        retry_next = retry_reg + 1'b1;
                    end
`else
                    state_next = PLL_RESET;
`endif
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STABLE: begin
                // Any dropout restarts the whole sequence; there is no glitch filter.
                if (relock_req || !locked_s) begin
                    state_next = PLL_RESET;
                    cnt_next   = '0;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
`ifdef PLL_LOCK_RETRY_LIMIT_EN
                    retry_next = '0;
`endif
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_next = PLL_RESET;
                    cnt_next   = '0;
                    if (loss_reg != {CNT_W{1'b1}}) begin
                        loss_next = loss_reg + 1'b1;
                    end
                end else if (relock_req) begin
                    state_next = PLL_RESET;
                    cnt_next   = '0;
                end
            end
`ifdef PLL_LOCK_RETRY_LIMIT_EN
            FAULT: begin
                if (relock_req) begin
                    state_next = PLL_RESET;
                    cnt_next   = '0;
                    retry_next = '0;
                end
            end
`endif
            default: begin
                state_next = PLL_RESET;
                cnt_next   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they change on the transition edge.
        pll_rst_next = (state_next == PLL_RESET);
        sys_rst_next = (state_next != RUN);
        ready_next   = (state_next == RUN);
`ifdef PLL_LOCK_RETRY_LIMIT_EN
        if (state_next == FAULT) begin
            pll_rst_next = 1'b1;
        end
        fault_next = (state_next == FAULT);
`endif
    end

    assign pll_rst         = pll_rst_reg;
    assign sys_rst         = sys_rst_reg;
    assign ready           = ready_reg;
    assign lock_loss_count = loss_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed timing checks plus a randomized run
// compared every cycle against a duration-based behavioural model.
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 50;
    localparam int STABLE_CYCLES = 8;
    localparam int CNT_W         = 2;
    localparam int MAX_RETRIES   = 3;
    localparam int LOSS_MAX      = (1 << CNT_W) - 1;
`ifdef PLL_LOCK_RETRY_LIMIT_EN
    localparam bit RETRY_LIMIT = 1'b1;
`else
    localparam bit RETRY_LIMIT = 1'b0;
`endif

    logic             refclk = 1'b0;
    logic             rst = 1'b1;
    logic             pll_locked = 1'b0;
    logic             relock_req = 1'b0;
    logic             pll_rst;
    logic             sys_rst;
    logic             ready;
    logic [CNT_W-1:0] lock_loss_count;
    logic             fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 refclk = ~refclk;

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .relock_req     (relock_req),
        .pll_rst        (pll_rst),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .lock_loss_count(lock_loss_count),
        .fault          (fault)
    );

    // Behavioural model: which phase the sequencer is in and how long it has been there.
    typedef enum {M_RESET, M_WAIT, M_STABLE, M_RUN, M_FAULT} phase_t;
    phase_t m_phase = M_RESET;
    int     m_elapsed = 0;
    int     m_losses = 0;
    int     m_timeouts = 0;
    bit     m_h1 = 1'b0;
    bit     m_h2 = 1'b0;
    bit     m_valid = 1'b0;

    task automatic enter(input phase_t p);
        m_phase   = p;
        m_elapsed = 0;
    endtask

    task automatic model_step();
        bit lk;
        lk   = m_h2;
        m_h2 = m_h1;
        m_h1 = pll_locked;
        if (rst) begin
            enter(M_RESET);
            m_losses   = 0;
            m_timeouts = 0;
            m_h1       = 1'b0;
            m_h2       = 1'b0;
            m_valid    = 1'b1;
            return;
        end
        if (!m_valid) return;
        case (m_phase)
            M_RESET: begin
                if (m_elapsed + 1 >= RST_CYCLES) enter(M_WAIT);
                else m_elapsed++;
            end
            M_WAIT: begin
                if (relock_req) enter(M_RESET);
                else if (lk) enter(M_STABLE);
                else if (m_elapsed + 1 >= LOCK_TIMEOUT) begin
                    m_timeouts++;
                    if (RETRY_LIMIT && m_timeouts >= MAX_RETRIES) enter(M_FAULT);
                    else enter(M_RESET);
                end else m_elapsed++;
            end
            M_STABLE: begin
                if (relock_req || !lk) enter(M_RESET);
                else if (m_elapsed + 1 >= STABLE_CYCLES) begin
                    enter(M_RUN);
                    m_timeouts = 0;
                end else m_elapsed++;
            end
            M_RUN: begin
                if (!lk) begin
                    m_losses = (m_losses < LOSS_MAX) ? m_losses + 1 : LOSS_MAX;
                    enter(M_RESET);
                end else if (relock_req) enter(M_RESET);
            end
            M_FAULT: begin
                if (relock_req) begin
                    enter(M_RESET);
                    m_timeouts = 0;
                end
            end
            default: enter(M_RESET);
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge refclk);
        model_step();
    end

    initial forever begin
        @(negedge refclk);
        if (m_valid) begin
            check("model pll_rst", pll_rst, (m_phase == M_RESET) || (m_phase == M_FAULT));
            check("model sys_rst", sys_rst, m_phase != M_RUN);
            check("model ready", ready, m_phase == M_RUN);
            check("model fault", fault, m_phase == M_FAULT);
            check("model lock_loss_count", lock_loss_count, m_losses);
        end
    end

    // Counts consecutive negedges (including the current one) with pll_rst at lvl.
    task automatic measure_pll_rst(input logic lvl, input int budget, output int n);
        n = 0;
        while (pll_rst === lvl && n < budget) begin
            n++;
            @(negedge refclk);
        end
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < budget) begin
            n++;
            @(negedge refclk);
        end
        check(name, ready, 1);
    endtask

    initial begin
        int n;
        int hold;
        int exp_loss[3] = '{2, 3, 3};
        bit fell;

        // Power-up
        rst = 1'b1;
        repeat (5) @(negedge refclk);
        rst = 1'b0;
        measure_pll_rst(1'b1, 20, n);
        check("powerup pll_rst width", n, RST_CYCLES);
        repeat (6) @(negedge refclk);
        pll_locked = 1'b1;
        for (n = 0; n < 40; n++) begin
            @(negedge refclk);
            if (sys_rst === 1'b0) break;
        end
        check("lock rise to sys_rst fall", n, STABLE_CYCLES + 2);
        check("powerup ready", ready, 1);
        check("powerup loss count", lock_loss_count, 0);

        // relock_req alone in RUN
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
        check("relock pll_rst", pll_rst, 1);
        wait_ready("relock re-ready", 60);
        check("relock loss count", lock_loss_count, 0);

        // relock_req coincident with a synchronized lock drop
        pll_locked = 1'b0;
        @(negedge refclk);
        @(negedge refclk);
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
        check("coincident pll_rst", pll_rst, 1);
        check("coincident loss count", lock_loss_count, 1);

        // Lock drop during STABLE
        measure_pll_rst(1'b1, 20, n);
        pll_locked = 1'b1;
        repeat (5) @(negedge refclk);
        pll_locked = 1'b0;
        fell = 1'b0;
        repeat (40) begin
            @(negedge refclk);
            if (sys_rst !== 1'b1) fell = 1'b1;
        end
        check("stable drop sys_rst held", fell, 0);
        check("stable drop loss count", lock_loss_count, 1);
        pll_locked = 1'b1;
        wait_ready("stable drop re-ready", 120);

        // Single-cycle lock losses in RUN; count saturates
        for (int k = 0; k < 3; k++) begin
            pll_locked = 1'b0;
            for (n = 1; n <= 10; n++) begin
                @(negedge refclk);
                if (n == 1) pll_locked = 1'b1;
                if (pll_rst === 1'b1) break;
            end
            check("loss pll_rst latency", n, 3);
            check("loss sys_rst", sys_rst, 1);
            check("loss ready", ready, 0);
            wait_ready("loss re-ready", 100);
            check("loss count", lock_loss_count, exp_loss[k]);
        end

        // Timeouts with lock held low
        pll_locked = 1'b0;
        for (n = 1; n <= 10; n++) begin
            @(negedge refclk);
            if (pll_rst === 1'b1) break;
        end
        check("timeout entry latency", n, 3);
        measure_pll_rst(1'b1, 100, n);
        check("timeout pulse 1", n, RST_CYCLES);
        measure_pll_rst(1'b0, 100, n);
        check("timeout wait 1", n, LOCK_TIMEOUT);
        measure_pll_rst(1'b1, 100, n);
        check("timeout pulse 2", n, RST_CYCLES);
        measure_pll_rst(1'b0, 100, n);
        check("timeout wait 2", n, LOCK_TIMEOUT);
        measure_pll_rst(1'b1, 100, n);
        check("timeout pulse 3", n, RST_CYCLES);
        measure_pll_rst(1'b0, 100, n);
        check("timeout wait 3", n, LOCK_TIMEOUT);
        check("timeout sys_rst", sys_rst, 1);
`ifdef PLL_LOCK_RETRY_LIMIT_EN
        check("fault set", fault, 1);
        measure_pll_rst(1'b1, 20, n);
        check("fault pll_rst held", n, 20);
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
        check("fault cleared", fault, 0);
`else
        measure_pll_rst(1'b1, 100, n);
        check("timeout pulse 4", n, RST_CYCLES);
        check("no fault", fault, 0);
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
`endif
        measure_pll_rst(1'b1, 100, n);
        check("relock pulse width", n, RST_CYCLES);

        // Randomized run
        hold = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge refclk);
            relock_req = ($urandom_range(0, 59) == 0);
            rst        = ($urandom_range(0, 799) == 0);
            if (hold == 0) begin
                pll_locked = ~pll_locked;
                hold = pll_locked ? $urandom_range(1, 120) : $urandom_range(1, 70);
            end else begin
                hold--;
            end
        end
        rst        = 1'b0;
        relock_req = 1'b0;
        @(negedge refclk);
        @(negedge refclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controls the PLL from the reference-clock side: drives the PLL reset and watches its lock output.
- Runs on the 100 MHz reference clock, so it never depends on the PLL's own output clocks.
- Holds the downstream system reset until the PLL has shown a stable lock for a set time.
- Re-initiates the PLL after a lock loss, a lock timeout or a software re-lock request, and counts lock-loss events for diagnostics.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per PLL reset pulse (>=1)
LOCK_TIMEOUT, 100000, cycles to wait for lock before re-pulsing pll_rst (>=1)
STABLE_CYCLES, 1024, cycles of continuous lock required before releasing sys_rst (>=1)
CNT_W, 8, width of lock_loss_count
MAX_RETRIES, 4, consecutive timeouts before FAULT (only with the optional feature)

Ports:
refclk  in  1  single clock, 100 MHz reference; all logic is synchronous to it
rst  in  1  synchronous, active-high block reset
pll_locked  in  1  PLL lock indicator, asynchronous to refclk
relock_req  in  1  single-cycle pulse requesting a forced PLL re-lock
pll_rst  out  1  registered reset to the PLL, active-high
sys_rst  out  1  registered downstream reset, active-high
ready  out  1  registered; high only in RUN
lock_loss_count  out  CNT_W  saturating count of lock losses seen in RUN
fault  out  1  retry-limit fault flag; tied 0 when the optional feature is absent

Behaviour:
- Synchronizer: pll_locked passes through a 2-flop synchronizer; its output is locked_s. Only locked_s is used by the FSM.
- Outputs are registered, with values decoded from the next state.
- Reset (rst=1): state=PLL_RESET, cycle counter cnt=0, pll_rst=1, sys_rst=1, ready=0, lock_loss_count=0, fault=0, synchronizer flops=0.
- Reset applied mid-operation behaves identically; lock_loss_count clears.
- FSM states:
  - PLL_RESET: pll_rst=1, sys_rst=1. cnt increments each cycle. When cnt==RST_CYCLES-1, go to WAIT_LOCK with cnt=0. pll_rst is therefore high for exactly RST_CYCLES cycles after rst release. relock_req is ignored in this state.
  - WAIT_LOCK: pll_rst=0, sys_rst=1. If locked_s=1, go to STABLE with cnt=0. Else if cnt==LOCK_TIMEOUT-1, timeout: go to PLL_RESET with cnt=0. Otherwise cnt increments.
  - STABLE: sys_rst=1. If locked_s=0, go to PLL_RESET. Else if cnt==STABLE_CYCLES-1, go to RUN. Otherwise cnt increments.
  - RUN: sys_rst=0, ready=1. If locked_s=0, go to PLL_RESET and increment lock_loss_count, saturating at 2^CNT_W-1.
- relock_req in WAIT_LOCK, STABLE or RUN: go to PLL_RESET with cnt=0. This is not counted as a lock loss.
- relock_req and a lock drop in the same RUN cycle: go to PLL_RESET and count the loss once.
- Timing:
  - Lock rise: if edge E0 first samples pll_locked=1 while in WAIT_LOCK, sys_rst falls at edge E0+STABLE_CYCLES+2.
  - Lock drop: if edge E0 samples pll_locked=0 while in RUN, sys_rst=1, pll_rst=1 and ready=0 at edge E0+2.
- Lock glitches shorter than one synchronized sample in STABLE still restart the full sequence (no filtering).
- cnt width is clog2 of max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES). cnt never wraps, because every compare-to-limit forces a transition.

Optional Feature:
Macro PLL_LOCK_RETRY_LIMIT_EN.
- Defined:
  - A retry counter increments on each WAIT_LOCK timeout and clears when RUN is entered.
  - When a timeout would make the retry count reach MAX_RETRIES, the FSM enters FAULT instead.
  - FAULT holds pll_rst=1, sys_rst=1, fault=1.
  - Only relock_req leaves FAULT: go to PLL_RESET, clear the retry counter, fault=0. rst also clears FAULT.
- Undefined: no FAULT state, no retry counter, fault tied 0; timeouts retry indefinitely.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=50, STABLE_CYCLES=8, CNT_W=2, MAX_RETRIES=3.
1. Power-up: rst high 5 cycles, then low; pll_locked=1 from cycle 10 -> pll_rst high exactly 4 cycles after release; sys_rst falls 10 edges after the first edge sampling lock; ready=1; lock_loss_count=0.
2. Lock loss in RUN: drop pll_locked for 1 cycle -> pll_rst/sys_rst high 2 edges later; full re-sequence; lock_loss_count=1. Repeat 4 losses -> count saturates at 3.
3. Timeout: hold pll_locked=0 -> pll_rst re-pulses (4 cycles) every 54 cycles; sys_rst stays high.
4. Drop during STABLE: lock at cycle t, drop at t+5 -> back to PLL_RESET; sys_rst never falls; lock_loss_count unchanged.
5. relock_req in RUN with a coincident lock drop -> PLL_RESET, count +1 once. relock_req alone -> PLL_RESET, count unchanged.
6. PLL_LOCK_RETRY_LIMIT_EN defined, lock held low -> fault=1 after the 3rd timeout with pll_rst held high. relock_req -> fault=0 and a 4-cycle pll_rst pulse. Macro undefined -> fault stays 0.
